// File: rtl/vrf_pkg.sv
// vrf_pkg -- shared vector register file constants and types.
//   DEPTH       : number of vector registers
//   BITS        : vector register width
//   AW          : register address width
//   vreg_addr_t : register index
//   vreg_data_t : register contents
//   DROP_MAX    : saturation value of the discarded-write counter
package vrf_pkg;
   localparam int DEPTH = 16;
   localparam int BITS  = 128;
   localparam int AW    = $clog2(DEPTH);

   typedef logic [AW-1:0]   vreg_addr_t;
   typedef logic [BITS-1:0] vreg_data_t;

   localparam logic [7:0] DROP_MAX = 8'd255;
endpackage

// File: rtl/rr_picker.sv
// rr_picker -- combinational round-robin selector.
//   req : request vector, one bit per requester
//   ptr : index where the search starts (wraps modulo N)
//   gnt : one-hot grant to the first set request at or after ptr, or zero
module rr_picker
   import vrf_pkg::*;
#(
   parameter int N  = 3,
   localparam int PW = (N > 1) ? $clog2(N) : 1
) (
   input  logic [N-1:0]  req,
   input  logic [PW-1:0] ptr,
   output logic [N-1:0]  gnt
);

   logic found;
   int   idx;

   always_comb begin
      gnt   = '0;
      found = 1'b0;
      idx   = 0;
      for (int k = 0; k < N; k++) begin
         idx = (int'(ptr) + k) % N;
         if (!found && req[idx]) begin
            gnt[idx] = 1'b1;
            found    = 1'b1;
         end
      end
   end

endmodule

// File: rtl/vrf_write_arbiter.sv
// vrf_write_arbiter -- round-robin arbitration of vector register file writes
// with a pending-write scoreboard.
//   clk, rst          : clock, synchronous active-high reset
//   req_valid/addr/data: per-requester write requests
//   req_ready         : combinational one-hot grant (transfer = valid & ready)
//   hold              : pipeline stall, suppresses all grants
//   rsv_valid/rsv_addr: issue-stage reservation, sets busy[rsv_addr]
//   busy              : registers with a write pending
//   writeEn/addressw/writeData : registered register-file write port
//   drop_count        : saturating count of grants that targeted register 0
module vrf_write_arbiter #(
   parameter int NREQ  = 3,
   parameter int DEPTH = vrf_pkg::DEPTH,
   parameter int BITS  = vrf_pkg::BITS,
   localparam int AW   = $clog2(DEPTH),
   localparam int PW   = (NREQ > 1) ? $clog2(NREQ) : 1
) (
   input  logic                           clk,
   input  logic                           rst,
   input  logic [NREQ-1:0]                req_valid,
   input  logic [NREQ-1:0][AW-1:0]        req_addr,
   input  logic [NREQ-1:0][BITS-1:0]      req_data,
   output logic [NREQ-1:0]                req_ready,
   input  logic                           hold,
   input  logic                           rsv_valid,
   input  logic [AW-1:0]                  rsv_addr,
   output logic [DEPTH-1:0]               busy,
   output logic                           writeEn,
   output logic [AW-1:0]                  addressw,
   output logic [BITS-1:0]                writeData,
   output logic [7:0]                     drop_count
);
   import vrf_pkg::*;

   logic [PW-1:0]    ptr_q, ptr_d;
   logic             writeEn_q, writeEn_d;
   logic [AW-1:0]    addressw_q, addressw_d;
   logic [BITS-1:0]  writeData_q, writeData_d;
   logic [DEPTH-1:0] busy_q, busy_d;
   logic [7:0]       drop_q, drop_d;

   logic [NREQ-1:0]  pick_gnt, gnt;
   logic             gnt_any;
   logic [PW-1:0]    gnt_idx;
   logic [AW-1:0]    sel_addr;
   logic [BITS-1:0]  sel_data;

   rr_picker #(.N(NREQ)) u_picker (
      .req (req_valid),
      .ptr (ptr_q),
      .gnt (pick_gnt)
   );

   // Reset also masks grants so nothing is consumed while the pipe is cleared.
   always_comb begin
      gnt = (rst || hold) ? '0 : pick_gnt;
   end

   assign req_ready = gnt;

   always_comb begin
      gnt_any  = 1'b0;
      gnt_idx  = '0;
      sel_addr = '0;
      sel_data = '0;
      for (int i = 0; i < NREQ; i++) begin
         if (gnt[i]) begin
            gnt_any  = 1'b1;
            gnt_idx  = PW'(i);
            sel_addr = req_addr[i];
            sel_data = req_data[i];
         end
      end
   end

   always_comb begin
      ptr_d       = ptr_q;
      writeEn_d   = 1'b0;
      addressw_d  = addressw_q;
      writeData_d = writeData_q;
      drop_d      = drop_q;
      if (gnt_any) begin
         ptr_d       = (gnt_idx == PW'(NREQ - 1)) ? '0 : gnt_idx + 1'b1;
         addressw_d  = sel_addr;
         writeData_d = sel_data;
         // Register 0 is hardwired; the request is consumed but never written.
         if (sel_addr == '0) begin
            if (drop_q != DROP_MAX) drop_d = drop_q + 8'd1;
         end else begin
            writeEn_d = 1'b1;
         end
      end
   end

   // Clear from the write leaving the port this cycle first, then apply the
   // reservation so a same-address set wins.
   always_comb begin
      busy_d = busy_q;
      if (writeEn_q) busy_d[addressw_q] = 1'b0;
      if (rsv_valid && rsv_addr != '0) busy_d[rsv_addr] = 1'b1;
      busy_d[0] = 1'b0;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         ptr_q       <= '0;
         writeEn_q   <= 1'b0;
         addressw_q  <= '0;
         writeData_q <= '0;
         busy_q      <= '0;
         drop_q      <= '0;
      end else begin
         ptr_q       <= ptr_d;
         writeEn_q   <= writeEn_d;
         addressw_q  <= addressw_d;
         writeData_q <= writeData_d;
         busy_q      <= busy_d;
         drop_q      <= drop_d;
      end
   end

   assign writeEn    = writeEn_q;
   assign addressw   = addressw_q;
   assign writeData  = writeData_q;
   assign busy       = busy_q;
   assign drop_count = drop_q;

endmodule

// File: tb/tb_vrf_write_arbiter.sv
module tb_vrf_write_arbiter;
   localparam int NREQ  = 3;
   localparam int DEPTH = 16;
   localparam int BITS  = 128;
   localparam int AW    = 4;

   logic                      clk = 1'b0;
   logic                      rst;
   logic [NREQ-1:0]           req_valid;
   logic [NREQ-1:0][AW-1:0]   req_addr;
   logic [NREQ-1:0][BITS-1:0] req_data;
   logic [NREQ-1:0]           req_ready;
   logic                      hold;
   logic                      rsv_valid;
   logic [AW-1:0]             rsv_addr;
   logic [DEPTH-1:0]          busy;
   logic                      writeEn;
   logic [AW-1:0]             addressw;
   logic [BITS-1:0]           writeData;
   logic [7:0]                drop_count;

   int errors = 0;
   int checks = 0;

   logic [BITS-1:0] d_a5, d_1, d_2, d_3;

   vrf_write_arbiter #(.NREQ(NREQ), .DEPTH(DEPTH), .BITS(BITS)) dut (
      .clk        (clk),
      .rst        (rst),
      .req_valid  (req_valid),
      .req_addr   (req_addr),
      .req_data   (req_data),
      .req_ready  (req_ready),
      .hold       (hold),
      .rsv_valid  (rsv_valid),
      .rsv_addr   (rsv_addr),
      .busy       (busy),
      .writeEn    (writeEn),
      .addressw   (addressw),
      .writeData  (writeData),
      .drop_count (drop_count)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [BITS-1:0] obs, input logic [BITS-1:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // advance one edge and sample away from it
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic settle();
      #1;
   endtask

   initial begin
      d_a5 = {16{8'hA5}};
      d_1  = {16{8'h11}};
      d_2  = {16{8'h22}};
      d_3  = {16{8'h33}};

      rst = 1'b1; hold = 1'b0; rsv_valid = 1'b0; rsv_addr = '0;
      req_valid = 3'b111; req_addr = '0; req_data = '0;
      step(); step();
      chk("rst_ready", req_ready, 3'b000);
      chk("rst_wen", writeEn, 1'b0);
      chk("rst_addr", addressw, 0);
      chk("rst_data", writeData, 0);
      chk("rst_busy", busy, 0);
      chk("rst_drop", drop_count, 0);
      rst = 1'b0; req_valid = 3'b000;
      step();

      // single requester
      req_valid = 3'b001; req_addr[0] = 4'd5; req_data[0] = d_a5; settle();
      chk("single_ready", req_ready, 3'b001);
      step();
      chk("single_wen", writeEn, 1'b1);
      chk("single_addr", addressw, 5);
      chk("single_data", writeData, d_a5);
      req_valid = 3'b000; settle();
      chk("idle_ready", req_ready, 3'b000);
      step();
      chk("idle_wen", writeEn, 1'b0);

      // ptr is 1 now; one grant to requester 2 returns it to 0
      req_valid = 3'b100; req_addr[2] = 4'd3; req_data[2] = d_3; settle();
      chk("wrap_ready", req_ready, 3'b100);
      step();
      chk("wrap_addr", addressw, 3);

      // contention from ptr=0
      req_valid = 3'b111;
      req_addr[0] = 4'd1; req_data[0] = d_1;
      req_addr[1] = 4'd2; req_data[1] = d_2;
      settle();
      chk("cont0_ready", req_ready, 3'b001);
      step();
      chk("cont0_addr", addressw, 1);
      chk("cont0_data", writeData, d_1);
      chk("cont1_ready", req_ready, 3'b010);
      step();
      chk("cont1_addr", addressw, 2);
      chk("cont1_data", writeData, d_2);
      chk("cont2_ready", req_ready, 3'b100);
      step();
      chk("cont2_addr", addressw, 3);
      chk("cont2_data", writeData, d_3);
      req_valid = 3'b101; settle();
      chk("skip_ready", req_ready, 3'b001);
      step();
      chk("skip_addr", addressw, 1);

      // hold with ptr=1
      hold = 1'b1; req_valid = 3'b111; settle();
      chk("hold0_ready", req_ready, 3'b000);
      step();
      chk("hold0_wen", writeEn, 1'b0);
      chk("hold1_ready", req_ready, 3'b000);
      step();
      chk("hold1_wen", writeEn, 1'b0);
      hold = 1'b0; settle();
      chk("resume_ready", req_ready, 3'b010);
      step();
      chk("resume_addr", addressw, 2);
      req_valid = 3'b101; settle();
      chk("resume2_ready", req_ready, 3'b100);
      step();
      chk("resume2_addr", addressw, 3);

      // register 0 writes (ptr=0)
      req_valid = 3'b001; req_addr[0] = 4'd0; settle();
      chk("r0_ready", req_ready, 3'b001);
      step();
      chk("r0_wen", writeEn, 1'b0);
      chk("r0_drop1", drop_count, 1);
      for (int i = 0; i < 299; i++) step();
      chk("r0_drop_sat", drop_count, 255);
      chk("r0_wen_end", writeEn, 1'b0);
      req_valid = 3'b000;

      // scoreboard
      rsv_valid = 1'b1; rsv_addr = 4'd7;
      step();
      chk("sb_set", busy, 16'h0080);
      rsv_valid = 1'b0; req_valid = 3'b001; req_addr[0] = 4'd7; req_data[0] = d_1;
      step();
      chk("sb_write_wen", writeEn, 1'b1);
      chk("sb_write_busy", busy, 16'h0080);
      req_valid = 3'b000; rsv_valid = 1'b1; rsv_addr = 4'd7;
      step();
      chk("sb_set_wins", busy, 16'h0080);
      rsv_valid = 1'b0; req_valid = 3'b001;
      step();
      chk("sb_write2_wen", writeEn, 1'b1);
      req_valid = 3'b000; rsv_valid = 1'b1; rsv_addr = 4'd9;
      step();
      chk("sb_clear_and_set", busy, 16'h0200);
      rsv_addr = 4'd0;
      step();
      chk("sb_addr0_ignored", busy, 16'h0200);
      rsv_addr = 4'd9;
      step();
      chk("sb_rereserve", busy, 16'h0200);
      rsv_valid = 1'b0;

      // reset mid-stream
      req_valid = 3'b111;
      req_addr[0] = 4'd1; req_addr[1] = 4'd2; req_addr[2] = 4'd3;
      step(); step();
      chk("pre_rst_wen", writeEn, 1'b1);
      rst = 1'b1; settle();
      chk("mid_rst_ready", req_ready, 3'b000);
      step();
      chk("mid_rst_wen", writeEn, 1'b0);
      chk("mid_rst_busy", busy, 0);
      chk("mid_rst_drop", drop_count, 0);
      chk("mid_rst_addr", addressw, 0);
      rst = 1'b0; settle();
      chk("post_rst_ready", req_ready, 3'b001);
      step();
      chk("post_rst_addr", addressw, 1);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/vrf_write_arbiter.md
VRF_WRITE_ARBITER -- requirements
Module: vrf_write_arbiter

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset; ports are clk and rst.
REQ-002 The block SHALL take these parameters (name, default, meaning):
- NREQ, 3, number of write requesters (load unit, vector ALU, key expansion).
- DEPTH, 16, number of vector registers.
- BITS, 128, vector register width.
REQ-003 The block SHALL have these ports (name, direction, width, meaning):
- clk, in, 1, clock.
- rst, in, 1, synchronous active-high reset.
- req_valid, in, NREQ, per-requester write request.
- req_addr, in, NREQ x clog2(DEPTH), per-requester destination register.
- req_data, in, NREQ x BITS, per-requester write data.
- req_ready, out, NREQ, grant strobe; a transfer occurs when valid and ready are both high.
- hold, in, 1, pipeline stall; no grants while high.
- rsv_valid, in, 1, issue-stage reservation strobe.
- rsv_addr, in, clog2(DEPTH), register being reserved.
- busy, out, DEPTH, scoreboard of registers with a pending write.
- writeEn, out, 1, register-file write enable.
- addressw, out, clog2(DEPTH), register-file write address.
- writeData, out, BITS, register-file write data.
- drop_count, out, 8, count of writes discarded because they targeted register 0.

Function
REQ-004 Each cycle with hold=0, the block SHALL grant exactly one valid requester, chosen round-robin; with no valid requester it SHALL grant none.
REQ-005 Round-robin rule: search starts at index ptr; after a grant to index i, ptr SHALL become (i+1) mod NREQ; ptr SHALL be unchanged in cycles with no grant.
REQ-006 req_ready SHALL be combinational, one-hot or zero, and asserted only for the granted valid requester. A requester that is not granted SHALL hold its valid, addr and data.
REQ-007 With hold=1, req_ready SHALL be all zero and ptr SHALL be unchanged.
REQ-008 Write port timing (latency 1 cycle):
- A grant in cycle N SHALL produce writeEn=1 in cycle N+1, with addressw and writeData equal to the granted addr and data.
- A cycle with no grant SHALL produce writeEn=0 in the next cycle.
REQ-009 Register 0 writes: a granted request with addr=0 SHALL be consumed (ready=1) but SHALL produce writeEn=0. drop_count SHALL increment and saturate at 255.
REQ-010 Scoreboard set: rsv_valid=1 SHALL set busy[rsv_addr] at the next edge. rsv_addr=0 SHALL be ignored; busy[0] is constantly 0.
REQ-011 Scoreboard clear: a registered write with writeEn=1 to address a SHALL clear busy[a] at the next edge.
REQ-012 Simultaneous set and clear of the same address: set SHALL win (busy stays 1). Different addresses SHALL both take effect.
REQ-013 Reserving an already-busy register SHALL leave it busy. No count of outstanding writes is kept.
REQ-014 writeData SHALL be a registered copy of the granted data; when writeEn=0 its value is don't-care.

Reset
REQ-015 While rst=1 at a clock edge, the block SHALL reset: writeEn=0, addressw=0, writeData=0, busy=0, drop_count=0, ptr=0.
REQ-016 While rst=1, req_ready SHALL be all zero, so no transfer is consumed.
REQ-017 A grant made in the cycle before rst rises SHALL NOT produce a write; the reset value wins at that edge.

Structure
REQ-018 DEPTH, BITS, the address-width constant and the vreg_addr_t and vreg_data_t typedefs SHALL live in the shared package vrf_pkg.
REQ-019 Round-robin selection SHALL be a separate sub-module, rr_picker: inputs are the request vector and ptr; output is the one-hot grant. It SHALL be purely combinational.
REQ-020 The block SHALL connect directly to the register file's writeEn, addressw and writeData ports, with no extra logic between them.

Verification
REQ-021 Single requester: req_valid=001, addr=5, data=0xA5 (repeated byte) -> ready=001 in cycle N; writeEn=1, addressw=5, writeData=0xA5.. in N+1.
REQ-022 Contention: all three requesters valid for 3 cycles starting from ptr=0 -> grants 001, 010, 100. Then requesters 0 and 2 valid -> grant 001.
REQ-023 Register 0: granted request with addr=0 -> ready=1, writeEn=0 next cycle, drop_count 0->1. After 300 such requests, drop_count=255.
REQ-024 Scoreboard: rsv_addr=7 in cycle N -> busy[7]=1 at N+1. A write to 7 coinciding with a new rsv_addr=7 leaves busy[7]=1. A later write alone clears it.
REQ-025 hold=1 for 2 cycles with all requesters valid -> ready=000, writeEn=0, ptr frozen. After release, grant resumes at the frozen ptr.
REQ-026 Reset mid-stream: rst=1 during continuous grants -> next cycle writeEn=0, busy=0, ptr=0. After release, first grant goes to requester 0.
